keypad_scanner: RTL

Row-scanning, debounced controller for the 5x2 board keypad; it sits directly upstream of `multi_cpu_top`'s I/O path. It drives `K_ROW`, samples `K_COL`, and turns one stable key press into a single key code. The code is held under a valid/ack handshake until the CPU-side I/O register consumes it.

---
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// Row-scanning, debounced 5x2 keypad controller.
// Turns one stable press into a key code held under a valid/ack handshake.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk_s,
  input  logic       rst_n,
  input  logic [1:0] K_COL,
  output logic [4:0] K_ROW,
  input  logic       key_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_CAND, S_PRESSED, S_REL} state_t;

  logic [1:0]        r_col_meta;
  logic [1:0]        r_col_sync;
  logic [SLOT_W-1:0] r_slot;
  logic [2:0]        r_row;
  logic [4:0]        r_k_row;
  logic [9:0]        r_marks;
  state_t            r_state;
  logic [3:0]        r_cand;
  logic [3:0]        r_cnt;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_down;
  logic              r_overrun;

  logic              w_sample;
  logic              w_frame_end;
  logic [9:0]        w_row_marks;
  logic [9:0]        w_frame;
  logic [3:0]        w_nkeys;
  logic [3:0]        w_key;
  logic              w_single;
  logic              w_report_c;

  assign w_sample    = (r_slot == SLOT_LAST);
  assign w_frame_end = w_sample && (r_row == 3'd4);

  // Keys marked by the current row's synchronized (active-low) columns.
  always_comb begin
    w_row_marks = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_row == 3'(i)) w_row_marks[2*i +: 2] = ~r_col_sync;
    end
  end

  assign w_frame = r_marks | w_row_marks;

  always_comb begin
    w_nkeys = '0;
    w_key   = '0;
    for (int i = 0; i < 10; i++) begin
      if (w_frame[i]) begin
        w_nkeys = w_nkeys + 4'd1;
        w_key   = 4'(i);
      end
    end
  end

  // Two or more marked keys are ghosting candidates and count as no key.
  assign w_single = (w_nkeys == 4'd1);

  // A report happens only on entry to PRESSED from IDLE/CAND, never on REL -> PRESSED.
  assign w_report_c = w_frame_end && w_single &&
                      (((r_state == S_IDLE) && (DB <= 4'd1)) ||
                       ((r_state == S_CAND) && (w_key == r_cand) && ((r_cnt + 4'd1) >= DB)));

  always_ff @(posedge clk_s) begin
    if (!rst_n) begin
      r_col_meta  <= 2'b11;
      r_col_sync  <= 2'b11;
      r_slot      <= '0;
      r_row       <= '0;
      r_k_row     <= 5'b11110;
      r_marks     <= '0;
      r_state     <= S_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_col_meta <= K_COL;
      r_col_sync <= r_col_meta;

      if (w_sample) begin
        r_slot  <= '0;
        r_row   <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
        r_k_row <= {r_k_row[3:0], r_k_row[4]};
        r_marks <= w_frame_end ? 10'd0 : w_frame;
      end else begin
        r_slot <= r_slot + SLOT_W'(1);
      end

      if (w_frame_end) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_key;
              if (DB <= 4'd1) begin
                r_state    <= S_PRESSED;
                r_cnt      <= '0;
                r_key_down <= 1'b1;
              end else begin
                r_state <= S_CAND;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_CAND: begin
            if (!w_single) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (w_key != r_cand) begin
              r_cand <= w_key;
              r_cnt  <= 4'd1;
            end else if ((r_cnt + 4'd1) >= DB) begin
              r_state    <= S_PRESSED;
              r_cnt      <= '0;
              r_key_down <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          S_PRESSED: begin
            if (!w_single) begin
              if (DB <= 4'd1) begin
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_key_down <= 1'b0;
              end else begin
                r_state <= S_REL;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_REL: begin
            if (w_single) begin
              r_state <= S_PRESSED;
              r_cnt   <= '0;
            end else if ((r_cnt + 4'd1) >= DB) begin
              r_state    <= S_IDLE;
              r_cnt      <= '0;
              r_key_down <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end

      // A report coinciding with ack replaces the code and clears overrun.
      if (w_report_c) begin
        if (!r_key_valid || key_ack) begin
          r_key_code  <= w_key;
          r_key_valid <= 1'b1;
          r_overrun   <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (key_ack && r_key_valid) begin
        r_key_valid <= 1'b0;
        r_overrun   <= 1'b0;
      end
    end
  end

  assign K_ROW     = r_k_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule
